// File: rtl/seq_multiplier_if.sv
// Start/busy/valid handshake bundle for the shared sequential multiplier.
// Signals:
//   start_i   request a new multiplication (master -> slave)
//   signed_i  1 = two's-complement operands, 0 = unsigned (master -> slave)
//   a_i, b_i  multiplicand / multiplier, WIDTH bits (master -> slave)
//   busy_o    multiplier is stepping through partial products (slave -> master)
//   valid_o   result_o holds a completed product (slave -> master)
//   result_o  2*WIDTH-bit product (slave -> master)
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned PW = 2 * WIDTH;

    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             valid_o;
    logic [PW-1:0]    result_o;

    modport master (
        output start_i,
        output signed_i,
        output a_i,
        output b_i,
        input  busy_o,
        input  valid_o,
        input  result_o
    );

    modport slave (
        input  start_i,
        input  signed_i,
        input  a_i,
        input  b_i,
        output busy_o,
        output valid_o,
        output result_o
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one
// partial-product step per clock. Signed operation multiplies magnitudes
// and negates the final sum, so the datapath itself is purely unsigned.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous active-high reset; aborts any running operation
//   mul_if  slave side of seq_multiplier_if (start/signed/a/b in,
//           busy/valid/result out); its WIDTH must match this module's
module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    seq_multiplier_if.slave mul_if
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [PW-1:0]      mcand_q,  mcand_d;   // |a| shifted left once per step
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // |b| shifted right; bit 0 is the current step's bit
    logic [PW-1:0]      acc_q,    acc_d;
    logic               neg_q,    neg_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [PW-1:0]      result_q, result_d;
    logic               busy_q,   busy_d;
    logic               valid_q,  valid_d;

    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [PW-1:0]      acc_sum_c;
    logic               last_step_c;

    // Operand magnitudes at capture; |-2^(W-1)| wraps to 2^(W-1), which is correct as unsigned
    always_comb begin
        a_neg_c = mul_if.signed_i & mul_if.a_i[WIDTH-1];
        b_neg_c = mul_if.signed_i & mul_if.b_i[WIDTH-1];
        a_mag_c = a_neg_c ? (~mul_if.a_i + WIDTH'(1)) : mul_if.a_i;
        b_mag_c = b_neg_c ? (~mul_if.b_i + WIDTH'(1)) : mul_if.b_i;
    end

    // Accumulator update for the current step
    always_comb begin
        acc_sum_c   = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step_c = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (mul_if.start_i) begin
                    state_d  = S_CALC;
                    mcand_d  = PW'(a_mag_c);
                    mplier_d = b_mag_c;
                    neg_d    = a_neg_c ^ b_neg_c;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_CALC: begin
                acc_d    = acc_sum_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (last_step_c) begin
                    // Negating zero yields zero mod 2^PW, so -0 never appears
                    result_d = neg_q ? (~acc_sum_c + PW'(1)) : acc_sum_c;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d == S_CALC);
        valid_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign mul_if.busy_o   = busy_q;
    assign mul_if.valid_o  = valid_q;
    assign mul_if.result_o = result_q;
endmodule
